// File: rtl/edge_fb_writer_if.sv
// Framebuffer write bus driven by edge_fb_writer.
// The master modport belongs to the writer. The slave modport belongs to the framebuffer RAM.
interface edge_fb_writer_if #(
   parameter int unsigned FB_SIZE = 16
) ();

   logic [FB_SIZE-1:0] addr_out;
   logic               pixel_out;
   logic               we_out;

   modport master (
      output addr_out,
      output pixel_out,
      output we_out
   );

   modport slave (
      input addr_out,
      input pixel_out,
      input we_out
   );

endinterface

// File: rtl/edge_fb_writer.sv
// Write side of the 1-bit edge framebuffer.
// - Decimates the thresholded Sobel stream 4x in each axis, using a horizontal OR per group.
// - Writes exactly one frame per start_in request.
// - Pulses frame_done_out once the final address has been written.
// Optional macro EDGE_FB_ROW_OR_EN also ORs vertically, through a one-line column buffer.
module edge_fb_writer #(
   parameter int unsigned SRC_WIDTH  = 1280,
   parameter int unsigned SRC_HEIGHT = 720,
   parameter int unsigned FB_WIDTH   = SRC_WIDTH / 4,
   parameter int unsigned FB_HEIGHT  = SRC_HEIGHT / 4,
   parameter int unsigned FB_SIZE    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [10:0]      hcount_in,
   input  logic [9:0]       vcount_in,
   input  logic             valid_in,
   input  logic             pixel_in,
   input  logic             start_in,
   edge_fb_writer_if.master fb,
   output logic             busy_out,
   output logic             frame_done_out
);

   localparam logic [10:0]        SrcW     = 11'(SRC_WIDTH);
   localparam logic [9:0]         SrcH     = 10'(SRC_HEIGHT);
   localparam logic [FB_SIZE-1:0] LastAddr = FB_SIZE'(FB_WIDTH * FB_HEIGHT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWaitSof,
      StCapture,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic               acc_q, acc_d;
   logic               we_q, we_d;
   logic [FB_SIZE-1:0] addr_q, addr_d;
   logic               pix_q, pix_d;

   logic               accept, sof, finish, take;
   logic               grp_first, grp_last;
   logic               h_or;
   logic               line_sel, wr_line;
   logic               wr_issue, wr_data;
   logic [7:0]         row;
   logic [8:0]         col;
   logic [FB_SIZE-1:0] row_base, wr_addr;

   assign accept    = valid_in && (hcount_in < SrcW) && (vcount_in < SrcH);
   assign sof       = accept && (hcount_in == 11'd0) && (vcount_in == 10'd0);
   // The last write is on the bus, so stop taking pixels and leave CAPTURE next cycle.
   assign finish    = we_q && (addr_q == LastAddr);
   assign take      = ((state_q == StCapture) && accept && !finish) ||
                      ((state_q == StWaitSof) && sof);
   assign grp_first = (hcount_in[1:0] == 2'd0);
   assign grp_last  = (hcount_in[1:0] == 2'd3);
   // OR of the group so far, including this pixel; the first pixel of a group reloads.
   assign h_or      = pixel_in | (grp_first ? 1'b0 : acc_q);

   assign row = vcount_in[9:2];
   assign col = hcount_in[10:2];

   // Row base address: the default x320 geometry uses shift-add, other geometries multiply.
   if (FB_WIDTH == 320) begin : g_x320
      assign row_base = (FB_SIZE'(row) << 8) + (FB_SIZE'(row) << 6);
   end else begin : g_xgen
      assign row_base = FB_SIZE'(row) * FB_SIZE'(FB_WIDTH);
   end

   assign wr_addr = row_base + FB_SIZE'(col);

`ifdef EDGE_FB_ROW_OR_EN
   localparam int unsigned ColW = $clog2(FB_WIDTH);

   logic [FB_WIDTH-1:0] lb_q, lb_d;
   logic [ColW-1:0]     lb_idx;

   assign lb_idx   = hcount_in[ColW+1:2];
   assign line_sel = 1'b1;
   assign wr_line  = (vcount_in[1:0] == 2'd3);
   assign wr_data  = lb_q[lb_idx] | h_or;

   // Column buffer: line 0 of each band loads, lines 1-2 OR in, and line 3 consumes.
   always_comb begin
      lb_d = lb_q;
      if (take && sof) begin
         lb_d = '0;
      end else if (take && grp_last) begin
         if (vcount_in[1:0] == 2'd0) begin
            lb_d[lb_idx] = h_or;
         end else if (vcount_in[1:0] != 2'd3) begin
            lb_d[lb_idx] = lb_q[lb_idx] | h_or;
         end
      end
   end

   // Column buffer register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         lb_q <= '0;
      end else begin
         lb_q <= lb_d;
      end
   end
`else
   assign line_sel = (vcount_in[1:0] == 2'd0);
   assign wr_line  = 1'b1;
   assign wr_data  = h_or;
`endif

   // Group accumulator and write issue. The accumulator clears after each write.
   // A group whose first pixel never arrives therefore starts from zero.
   always_comb begin
      acc_d    = acc_q;
      wr_issue = 1'b0;
      if (take && line_sel) begin
         acc_d    = grp_last ? 1'b0 : h_or;
         wr_issue = grp_last && wr_line;
      end
   end

   // Next values of the registered write bus. The address and data hold when no write is issued.
   always_comb begin
      we_d   = wr_issue;
      addr_d = addr_q;
      pix_d  = pix_q;
      if (wr_issue) begin
         addr_d = wr_addr;
         pix_d  = wr_data;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc_q  <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         pix_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         pix_q  <= pix_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state. A SOF in CAPTURE restarts in place, because addresses derive from the counts.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start_in) state_d = StWaitSof;
         StWaitSof: if (sof) state_d = StCapture;
         StCapture: if (finish) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy_out       = (state_q == StWaitSof) || (state_q == StCapture);
      frame_done_out = (state_q == StDone);
   end

   assign fb.addr_out  = addr_q;
   assign fb.pixel_out = pix_q;
   assign fb.we_out    = we_q;

endmodule

// File: tb/tb_edge_fb_writer.sv
// Directed bench for edge_fb_writer.
// A full-size instance checks the 57600-write frame and its final address.
// A reduced-geometry instance (64x32 -> 16x8) checks the protocol cases.
// Both instances share the pixel stream but have separate start requests.
module tb_edge_fb_writer;

   localparam int SW = 64;
   localparam int SH = 32;
   localparam int FW = 16;
   localparam int FH = 8;
   localparam int FS = 7;
`ifdef EDGE_FB_ROW_OR_EN
   localparam int   SelLine   = 3;
   localparam logic ExpSingle = 1'b1;
`else
   localparam int   SelLine   = 0;
   localparam logic ExpSingle = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        valid, pixel, start_s, start_b;
   logic        busy_s, done_s, busy_b, done_b;

   int n_vec, n_err, cyc, last_pix_cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   edge_fb_writer_if #(.FB_SIZE(FS)) s_if ();
   edge_fb_writer_if #(.FB_SIZE(16)) b_if ();

   edge_fb_writer #(
      .SRC_WIDTH (SW),
      .SRC_HEIGHT(SH),
      .FB_WIDTH  (FW),
      .FB_HEIGHT (FH),
      .FB_SIZE   (FS)
   ) u_dut_small (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .hcount_in     (hcount),
      .vcount_in     (vcount),
      .valid_in      (valid),
      .pixel_in      (pixel),
      .start_in      (start_s),
      .fb            (s_if),
      .busy_out      (busy_s),
      .frame_done_out(done_s)
   );

   edge_fb_writer u_dut (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .hcount_in     (hcount),
      .vcount_in     (vcount),
      .valid_in      (valid),
      .pixel_in      (pixel),
      .start_in      (start_b),
      .fb            (b_if),
      .busy_out      (busy_b),
      .frame_done_out(done_b)
   );

   // Write monitors, sampled on the falling edge.
   int            s_wr_cnt, s_done_cnt, s_done_cyc, s_we_idle;
   logic          s_fb  [0:(1<<FS)-1];
   logic [FS-1:0] s_log [0:4095];
   int            b_wr_cnt, b_done_cnt, b_done_cyc, b_we_idle;
   logic [15:0]   b_last_addr;
   logic          b_fb  [0:65535];

   always @(negedge clk) begin
      if (s_if.we_out) begin
         s_fb[s_if.addr_out]  <= s_if.pixel_out;
         s_log[s_wr_cnt[11:0]] <= s_if.addr_out;
         s_wr_cnt             <= s_wr_cnt + 1;
         if (!busy_s) s_we_idle <= s_we_idle + 1;
      end
      if (done_s) begin
         s_done_cnt <= s_done_cnt + 1;
         s_done_cyc <= cyc;
      end
   end

   always @(negedge clk) begin
      if (b_if.we_out) begin
         b_fb[b_if.addr_out] <= b_if.pixel_out;
         b_last_addr         <= b_if.addr_out;
         b_wr_cnt            <= b_wr_cnt + 1;
         if (!busy_b) b_we_idle <= b_we_idle + 1;
      end
      if (done_b) begin
         b_done_cnt <= b_done_cnt + 1;
         b_done_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Presents one input cycle. The request strobes drop unless a caller raises them afterwards.
   task automatic drive(input logic v, input int h, input int vc, input logic p);
      @(posedge clk);
      #1;
      valid   = v;
      hcount  = 11'(h);
      vcount  = 10'(vc);
      pixel   = p;
      start_s = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
   endtask

   function automatic logic pat(input int mode, input int h, input int v);
      case (mode)
         1:       return (h == 5);
         2:       return (h == 6) && (v == 2);
         default: return 1'b0;
      endcase
   endfunction

   // Streams a reduced frame, with blanking and out-of-range cycles after every line.
   task automatic stream_small(input int mode, input int nlines, input int start_line);
      for (int v = 0; v < nlines; v++) begin
         for (int h = 0; h < SW; h++) begin
            drive(1'b1, h, v, pat(mode, h, v));
            if (v == start_line && h == 10) start_s = 1'b1;
            if (h == SW - 1 && v == SH - 4 + SelLine) last_pix_cyc = cyc;
         end
         for (int h = SW; h < SW + 6; h++) drive(1'b0, h, v, 1'b1);
         drive(1'b0, 7, v, 1'b1);
         drive(1'b1, SW + 3, v, 1'b1);
         drive(1'b1, 3, SH, 1'b1);
      end
   endtask

   // Full-size frame reduced to the SOF pixel plus the group-closing pixel of every written group.
   task automatic stream_big_sparse();
      drive(1'b1, 0, 0, 1'b0);
      for (int r = 0; r < 180; r++) begin
         for (int c = 0; c < 320; c++) begin
            drive(1'b1, 4 * c + 3, 4 * r + SelLine, (r == 1 && c == 1) || (r == 179 && c == 319));
            if (r == 179 && c == 319) last_pix_cyc = cyc;
         end
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, d0, snap;
      rst_n   = 1'b0;
      valid   = 1'b0;
      hcount  = '0;
      vcount  = '0;
      pixel   = 1'b0;
      start_s = 1'b0;
      start_b = 1'b0;

      // Reset is held while the stream and the requests are active.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, i, 0, 1'b1);
         start_s = 1'b1;
         start_b = 1'b1;
      end
      check("rst_we", s_if.we_out, 0);
      check("rst_busy", busy_s, 0);
      check("rst_done", done_s, 0);
      check("rst_addr", s_if.addr_out, 0);
      check("rst_pixel", s_if.pixel_out, 0);
      check("rst_big_busy", busy_b, 0);
      drive(1'b0, 0, 0, 1'b0);
      rst_n = 1'b1;
      idle(5);
      check("post_rst_busy", busy_s, 0);
      check("post_rst_writes", s_wr_cnt, 0);

      // No request, so a full frame produces no writes.
      w0 = s_wr_cnt;
      d0 = s_done_cnt;
      stream_small(1, SH, -1);
      idle(4);
      check("idle_writes", s_wr_cnt - w0, 0);
      check("idle_busy", busy_s, 0);
      check("idle_done", s_done_cnt - d0, 0);

      // Full-size frame.
      idle(1);
      start_b = 1'b1;
      idle(2);
      check("big_busy_wait", busy_b, 1);
      w0 = b_wr_cnt;
      stream_big_sparse();
      idle(4);
      check("big_writes", b_wr_cnt - w0, 57600);
      check("big_last_addr", b_last_addr, 57599);
      check("big_done_cnt", b_done_cnt, 1);
      check("big_done_lat", b_done_cyc - last_pix_cyc, 2);
      check("big_addr321", b_fb[321], 1);
      check("big_addr320", b_fb[320], 0);
      check("big_addr57599", b_fb[57599], 1);
      check("big_we_idle", b_we_idle, 0);
      check("big_busy_end", busy_b, 0);

      // Reduced full frame with a 1 at hcount 5. A start_in during CAPTURE must be ignored.
      w0 = s_wr_cnt;
      d0 = s_done_cnt;
      idle(1);
      start_s = 1'b1;
      stream_small(1, SH, 10);
      idle(4);
      check("frame_writes", s_wr_cnt - w0, FW * FH);
      check("frame_done_cnt", s_done_cnt - d0, 1);
      check("frame_done_lat", s_done_cyc - last_pix_cyc, 2);
      check("frame_addr1", s_fb[1], 1);
      check("frame_addr0", s_fb[0], 0);
      check("frame_addr17", s_fb[FW + 1], 1);
      check("frame_we_idle", s_we_idle, 0);
      check("frame_busy_end", busy_s, 0);

      // Upstream restarts mid-frame with a new SOF.
      d0 = s_done_cnt;
      idle(1);
      start_s = 1'b1;
      stream_small(0, SH / 2, -1);
      snap = s_wr_cnt;
      check("restart_no_done", s_done_cnt - d0, 0);
      stream_small(1, SH, -1);
      idle(4);
      check("restart_first_addr", s_log[snap[11:0]], 0);
      check("restart_writes", s_wr_cnt - snap, FW * FH);
      check("restart_done_cnt", s_done_cnt - d0, 1);
      check("restart_done_lat", s_done_cyc - last_pix_cyc, 2);

      // Single 1 at hcount 6, vcount 2. Only the vertical OR carries it to address 1.
      w0 = s_wr_cnt;
      d0 = s_done_cnt;
      idle(1);
      start_s = 1'b1;
      stream_small(2, SH, -1);
      idle(4);
      check("single_addr1", s_fb[1], ExpSingle);
      check("single_addr17", s_fb[FW + 1], 0);
      check("single_writes", s_wr_cnt - w0, FW * FH);
      check("single_done_cnt", s_done_cnt - d0, 1);

      // Reset mid-capture abandons the frame.
      d0 = s_done_cnt;
      idle(1);
      start_s = 1'b1;
      stream_small(0, 6, -1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy_s, 0);
      check("midrst_we", s_if.we_out, 0);
      idle(2);
      rst_n = 1'b1;
      idle(10);
      check("midrst_done", s_done_cnt - d0, 0);
      check("midrst_busy_after", busy_s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/edge_fb_writer.md
Name: edge_fb_writer

Overview:
- Write side of the 1-bit 320x180 edge framebuffer that key_boundary_x scans.
- Takes the thresholded Sobel edge stream at camera resolution (1280x720) and decimates it 4x in each axis, combining pixels by horizontal OR.
- Writes exactly one complete frame per request, then pulses frame_done_out so the boundary scanner can start reading a coherent image.

Parameters:
- SRC_WIDTH, 1280, input active pixels per line.
- SRC_HEIGHT, 720, input active lines per frame.
- FB_WIDTH, 320, framebuffer width; must equal SRC_WIDTH/4.
- FB_HEIGHT, 180, framebuffer height; must equal SRC_HEIGHT/4.
- FB_SIZE, $clog2(FB_WIDTH*FB_HEIGHT) = 16, address width.

Ports:
- clk_in  input  1  system clock; all logic in this single domain.
- rst_in  input  1  asynchronous, active-low reset.
- hcount_in  input  11  column of pixel_in.
- vcount_in  input  10  line of pixel_in.
- valid_in  input  1  pixel_in/hcount_in/vcount_in are valid this cycle.
- pixel_in  input  1  thresholded Sobel edge bit.
- start_in  input  1  single-cycle capture request from the reader side.
- addr_out  output  FB_SIZE  framebuffer write address.
- pixel_out  output  1  framebuffer write data.
- we_out  output  1  framebuffer write enable.
- busy_out  output  1  high in WAIT_SOF and CAPTURE.
- frame_done_out  output  1  single-cycle pulse when a full frame has been written.

Behaviour:
- Reset: asynchronous assert on rst_in low; all state clears immediately.
  - Outputs: addr_out=0, pixel_out=0, we_out=0, busy_out=0, frame_done_out=0.
  - State goes to IDLE; accumulator clears.
  - Reset mid-capture abandons the frame; no frame_done_out pulse.
- Pixel acceptance: a pixel is accepted only when valid_in=1, hcount_in<SRC_WIDTH and vcount_in<SRC_HEIGHT. All other pixels are ignored.
- States:
  - IDLE: no writes. start_in -> WAIT_SOF.
  - WAIT_SOF: waits for an accepted pixel with hcount_in=0 and vcount_in=0 (SOF). On SOF, moves to CAPTURE and that SOF pixel is processed.
  - CAPTURE: decimates and writes. Last framebuffer write -> DONE.
  - DONE: frame_done_out=1 for exactly one cycle, then IDLE.
- start_in handling: ignored in WAIT_SOF, CAPTURE and DONE. A start_in in the same cycle as the DONE pulse is also ignored.
- SOF during CAPTURE (upstream restart): capture restarts at address 0. The current accumulator is discarded and no frame_done_out pulse is issued.
- Decimation, applied only when the line is selected (vcount_in[1:0]==0):
  - hcount_in[1:0]==0: acc <= pixel_in.
  - Otherwise: acc <= acc | pixel_in.
  - hcount_in[1:0]==3: a write is issued with data acc|pixel_in.
  - Lines with vcount_in[1:0]!=0 are ignored.
- Write timing: registered, one cycle of latency. Accepted 4th pixel at cycle t gives, at t+1:
  - we_out=1;
  - addr_out = (vcount_in>>2)*FB_WIDTH + (hcount_in>>2);
  - pixel_out = OR of the group.
- Arithmetic: address computed in FB_SIZE bits; the x320 multiply is implemented as shift-add (x256 + x64). Maximum address is 57599.
- Missing pixels: a group whose first pixel (hcount[1:0]==0) was not accepted still writes, using the stale-free acc cleared at line start.
- Completion: the write to address FB_WIDTH*FB_HEIGHT-1 (57599) causes DONE on the next cycle, i.e. frame_done_out at t+2 relative to the accepted pixel.
- Write enable: we_out is high for exactly one cycle per group and never high outside CAPTURE.
  - In IDLE, WAIT_SOF and DONE, we_out=0 and addr_out/pixel_out hold their last values.
- busy_out: combinational from state; high in WAIT_SOF and CAPTURE.

Optional Feature:
- Macro: EDGE_FB_ROW_OR_EN.
- Defined:
  - Vertical OR also applies.
  - A FB_WIDTH-bit line buffer accumulates the horizontal-OR result for each column across lines with vcount[1:0]=0..3. Line 0 loads, lines 1-2 OR in.
  - The write is issued on lines with vcount[1:0]==3, with data equal to the OR of all 16 pixels.
  - Address uses vcount>>2 as before. The line buffer clears on SOF and on reset.
  - The last write, and therefore frame_done_out, occurs on source line 719.
- Undefined:
  - Only lines with vcount[1:0]==0 are sampled, as specified above.
  - No line buffer is synthesized.
  - The last write occurs on source line 716.

Test Plan:
- Reset: hold rst_in low with stimulus running -> we_out=0, busy_out=0, no frame_done_out; release -> still IDLE, no writes until start_in.
- Full frame, pixel_in=1 only at hcount 5, lines 0..719, start_in pulsed before SOF:
  - exactly 57600 writes;
  - addr 1 (row 0, col 1) pixel_out=1; addr 0 pixel_out=0; addr 321 pixel_out=1;
  - one frame_done_out pulse two cycles after the hcount 1279 / vcount 716 pixel (macro off).
- Request ignored in IDLE: no start_in, full frame streamed -> zero writes, busy_out=0.
- Mid-frame SOF: restart at vcount 400 with a new SOF -> next write goes to address 0; frame_done_out fires only after the second frame completes; write count from the restart is 57600.
- Gating: valid_in=0 across hcount 1280..1599 with out-of-range counts -> no writes; start_in during CAPTURE -> no effect, single frame_done_out.
- EDGE_FB_ROW_OR_EN defined, single 1 at hcount 6, vcount 2:
  - write to addr 1 with pixel_out=1, issued on line 3;
  - macro undefined with the same stimulus -> addr 1 pixel_out=0.
